key_event_tracker: RTL and testbench

- Sits between the SoC keycode PIO exports (keycode0/keycode1) and the character/background control logic.
- Samples the two USB HID keycode slots once per video frame and produces per-key held levels plus one-cycle press and release pulses for six game keys.
- Runs a Space-bar charge-jump state machine: how long Space is held sets the strength of a jump request, and J cancels a charge in progress.
- Moves frame-rate key handling out of the character module into one registered, synchronous stage.

---
 rtl/key_event_tracker.sv | 142 ++++++++++++++
 tb/tb_key_event_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_tracker.sv
// Frame-synchronous keyboard front end: samples two HID keycode slots once per
// VGA frame, emits per-key levels/press/release, and runs a Space charge-jump FSM.
module key_event_tracker #(
    parameter int CNT_W      = 6,
    parameter int MAX_CHARGE = 40,
    parameter int MIN_CHARGE = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       keycode0,
    input  logic [7:0]       keycode1,
    output logic [5:0]       key_held,
    output logic [5:0]       key_press,
    output logic [5:0]       key_release,
    output logic             frame_tick,
    output logic             charging,
    output logic             jump_valid,
    output logic [CNT_W-1:0] jump_charge
);

    localparam logic [7:0] KC_A        = 8'h04;
    localparam logic [7:0] KC_D        = 8'h07;
    localparam logic [7:0] KC_W        = 8'h1A;
    localparam logic [7:0] KC_S        = 8'h16;
    localparam logic [7:0] KC_SPACE    = 8'h2C;
    localparam logic [7:0] KC_J        = 8'h0D;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;

    localparam int BIT_SPACE = 4;
    localparam int BIT_J     = 5;

    typedef enum logic {IDLE, CHARGING} state_t;

    function automatic logic slot_hit(input logic [7:0] k0, input logic [7:0] k1,
                                      input logic [7:0] code);
        return (k0 == code) || (k1 == code);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(MAX_CHARGE))
            return CNT_W'(MAX_CHARGE);
        else
            return c + CNT_W'(1);
    endfunction

    logic             frame_sync_p0;
    logic             frame_sync_p1;
    logic             frame_prev_p2;
    logic             upd_vld_p1;
    logic [5:0]       key_now;
    logic             rollover;
    state_t           state;
    logic [CNT_W-1:0] count;

    // Stage 0-2: two-flop synchronizer on VGA_VS, then registered rising-edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_prev_p2 <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            frame_sync_p0 <= frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_prev_p2 <= frame_sync_p1;
            frame_tick    <= frame_sync_p1 & ~frame_prev_p2;
        end
    end

    // Zero codes never match any key, so empty slots need no special case.
    assign key_now  = {slot_hit(keycode0, keycode1, KC_J),
                       slot_hit(keycode0, keycode1, KC_SPACE),
                       slot_hit(keycode0, keycode1, KC_S),
                       slot_hit(keycode0, keycode1, KC_W),
                       slot_hit(keycode0, keycode1, KC_D),
                       slot_hit(keycode0, keycode1, KC_A)};
    assign rollover = (keycode0 == KC_ROLLOVER) || (keycode1 == KC_ROLLOVER);

    // Update stage: a rollover frame is dropped entirely, including for the FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            upd_vld_p1  <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            upd_vld_p1  <= frame_tick & ~rollover;
            if (frame_tick && !rollover) begin
                key_held    <= key_now;
                key_press   <= key_now & ~key_held;
                key_release <= ~key_now & key_held;
            end
        end
    end

    // FSM stage: consumes the update-cycle pulses, result lands one cycle later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= '0;
            charging    <= 1'b0;
            jump_valid  <= 1'b0;
            jump_charge <= '0;
        end else begin
            jump_valid <= 1'b0;
            if (upd_vld_p1) begin
                case (state)
                    IDLE: begin
                        if (key_press[BIT_SPACE] && !key_press[BIT_J]) begin
                            state    <= CHARGING;
                            count    <= CNT_W'(1);
                            charging <= 1'b1;
                        end
                    end
                    CHARGING: begin
                        if (key_press[BIT_J]) begin
                            state    <= IDLE;
                            charging <= 1'b0;
                        end else if (key_release[BIT_SPACE]) begin
                            state    <= IDLE;
                            charging <= 1'b0;
                            if (count >= CNT_W'(MIN_CHARGE)) begin
                                jump_valid  <= 1'b1;
                                jump_charge <= count;
                            end
                        end else begin
                            count <= sat_inc(count);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        charging <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_tracker.sv
// Directed bench for key_event_tracker: frame timing, key decode, press/release
// pulses, rollover skip, and the Space charge-jump FSM including cancel and reset.
module tb_key_event_tracker;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [5:0] key_held;
    logic [5:0] key_press;
    logic [5:0] key_release;
    logic       frame_tick;
    logic       charging;
    logic       jump_valid;
    logic [5:0] jump_charge;

    key_event_tracker #(.CNT_W(6), .MAX_CHARGE(40), .MIN_CHARGE(3)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .keycode0(keycode0), .keycode1(keycode1),
        .key_held(key_held), .key_press(key_press), .key_release(key_release),
        .frame_tick(frame_tick), .charging(charging),
        .jump_valid(jump_valid), .jump_charge(jump_charge)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    int         f_tick_cnt, f_tick_pos, f_jv_cnt;
    logic [5:0] f_press, f_rel, f_held, f_jc;
    logic       f_jv, f_chg, f_stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: frame_clk high for 8 edges, low for 4; snapshot the tick,
    // update (edge 4) and FSM-result (edge 5) cycles.
    task automatic run_frame(input logic [7:0] k0, input logic [7:0] k1);
        f_tick_cnt = 0;
        f_tick_pos = 0;
        f_jv_cnt   = 0;
        @(negedge Clk);
        keycode0  = k0;
        keycode1  = k1;
        frame_clk = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge Clk);
            #1;
            if (frame_tick) begin
                f_tick_cnt++;
                f_tick_pos = e;
            end
            if (jump_valid) f_jv_cnt++;
            if (e == 4) begin
                f_press = key_press;
                f_rel   = key_release;
                f_held  = key_held;
            end
            if (e == 5) begin
                f_jv    = jump_valid;
                f_jc    = jump_charge;
                f_chg   = charging;
                f_stuck = |{key_press, key_release};
            end
            if (e == 8) begin
                @(negedge Clk);
                frame_clk = 1'b0;
            end
        end
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        keycode0  = 8'h00;
        keycode1  = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_held",   32'(key_held),    32'h0);
        chk("rst_press",  32'(key_press),   32'h0);
        chk("rst_rel",    32'(key_release), 32'h0);
        chk("rst_tick",   32'(frame_tick),  32'h0);
        chk("rst_chg",    32'(charging),    32'h0);
        chk("rst_jv",     32'(jump_valid),  32'h0);
        chk("rst_jc",     32'(jump_charge), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // A held for three frames
        run_frame(8'h04, 8'h00);
        chk("a1_tick_cnt", 32'(f_tick_cnt), 32'd1);
        chk("a1_tick_pos", 32'(f_tick_pos), 32'd3);
        chk("a1_press",    32'(f_press),    32'h01);
        chk("a1_held",     32'(f_held),     32'h01);
        chk("a1_rel",      32'(f_rel),      32'h00);
        chk("a1_one_cyc",  32'(f_stuck),    32'h0);
        for (int i = 0; i < 2; i++) begin
            run_frame(8'h04, 8'h00);
            chk("a_rep_tick",  32'(f_tick_cnt), 32'd1);
            chk("a_rep_press", 32'(f_press),    32'h00);
            chk("a_rep_held",  32'(f_held),     32'h01);
            chk("a_rep_rel",   32'(f_rel),      32'h00);
        end
        @(negedge Clk);
        keycode0 = 8'h07;
        repeat (5) @(posedge Clk);
        #1;
        chk("between_held",  32'(key_held),  32'h01);
        chk("between_press", 32'(key_press), 32'h00);

        // D+W, then S alone, then nothing
        run_frame(8'h07, 8'h1A);
        chk("dw_press", 32'(f_press), 32'h06);
        chk("dw_rel",   32'(f_rel),   32'h01);
        chk("dw_held",  32'(f_held),  32'h06);
        run_frame(8'h16, 8'h00);
        chk("s_held",   32'(f_held),  32'h08);
        chk("s_press",  32'(f_press), 32'h08);
        chk("s_rel",    32'(f_rel),   32'h06);
        run_frame(8'h00, 8'h00);
        chk("none_held", 32'(f_held), 32'h00);
        chk("none_rel",  32'(f_rel),  32'h08);

        // Space for 10 frames then release: jump of strength 10
        for (int i = 1; i <= 10; i++) begin
            run_frame(8'h2C, 8'h00);
            if (i == 1) chk("sp10_press", 32'(f_press), 32'h10);
            chk("sp10_chg", 32'(f_chg), 32'h1);
            chk("sp10_nojv", 32'(f_jv_cnt), 32'd0);
        end
        run_frame(8'h00, 8'h00);
        chk("sp10_rel",    32'(f_rel),    32'h10);
        chk("sp10_jv",     32'(f_jv),     32'h1);
        chk("sp10_jv_cnt", 32'(f_jv_cnt), 32'd1);
        chk("sp10_jc",     32'(f_jc),     32'd10);
        chk("sp10_chg_off", 32'(f_chg),   32'h0);

        // Space for 60 frames: count saturates at 40
        for (int i = 0; i < 60; i++) run_frame(8'h2C, 8'h00);
        chk("sp60_chg", 32'(f_chg), 32'h1);
        run_frame(8'h00, 8'h00);
        chk("sp60_jv_cnt", 32'(f_jv_cnt), 32'd1);
        chk("sp60_jc",     32'(f_jc),     32'd40);

        // Space for 2 frames: too short, prior strength kept
        run_frame(8'h2C, 8'h00);
        run_frame(8'h2C, 8'h00);
        run_frame(8'h00, 8'h00);
        chk("sp2_jv_cnt", 32'(f_jv_cnt), 32'd0);
        chk("sp2_jc",     32'(f_jc),     32'd40);
        chk("sp2_chg",    32'(f_chg),    32'h0);

        // Space for 5 frames, then J pressed as Space released: cancel
        for (int i = 0; i < 5; i++) run_frame(8'h2C, 8'h00);
        run_frame(8'h00, 8'h0D);
        chk("cancel_press",  32'(f_press),    32'h20);
        chk("cancel_rel",    32'(f_rel),      32'h10);
        chk("cancel_jv_cnt", 32'(f_jv_cnt),   32'd0);
        chk("cancel_chg",    32'(f_chg),      32'h0);
        chk("cancel_jc",     32'(f_jc),       32'd40);
        run_frame(8'h00, 8'h00);
        chk("j_rel", 32'(f_rel), 32'h20);

        // Space in both slots is one press; rollover frame is skipped
        run_frame(8'h2C, 8'h2C);
        chk("dup_press", 32'(f_press), 32'h10);
        chk("dup_held",  32'(f_held),  32'h10);
        chk("dup_chg",   32'(f_chg),   32'h1);
        run_frame(8'h00, 8'h01);
        chk("roll_tick",  32'(f_tick_cnt), 32'd1);
        chk("roll_held",  32'(f_held),     32'h10);
        chk("roll_press", 32'(f_press),    32'h00);
        chk("roll_rel",   32'(f_rel),      32'h00);
        chk("roll_chg",   32'(f_chg),      32'h1);

        // Reset mid-charge clears everything on the next edge
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("mrst_held", 32'(key_held),    32'h0);
        chk("mrst_chg",  32'(charging),    32'h0);
        chk("mrst_jc",   32'(jump_charge), 32'h0);
        chk("mrst_jv",   32'(jump_valid),  32'h0);
        @(negedge Clk);
        Reset    = 1'b0;
        keycode0 = 8'h00;
        keycode1 = 8'h00;
        run_frame(8'h00, 8'h00);
        chk("post_rst_jv", 32'(f_jv_cnt), 32'd0);

        // Space and J pressed together from IDLE: no charge starts
        run_frame(8'h2C, 8'h0D);
        chk("spj_press", 32'(f_press), 32'h30);
        chk("spj_chg",   32'(f_chg),   32'h0);
        run_frame(8'h00, 8'h00);
        chk("spj_rel",    32'(f_rel),    32'h30);
        chk("spj_jv_cnt", 32'(f_jv_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
